// File: rtl/chrono_counter_if.sv
// Control and display bus of the stopwatch/timer core.
// The master side drives the control pulses and presets; the slave side returns time, lap and status.
interface chrono_counter_if #(
  parameter int HOURS_W = 4
);
  logic               start_stop;
  logic               clear;
  logic               load;
  logic               mode;
  logic               lap;
  logic [HOURS_W-1:0] pre_h;
  logic [5:0]         pre_m;
  logic [5:0]         pre_s;
  logic [9:0]         pre_ms;

  logic [HOURS_W-1:0] hours;
  logic [5:0]         minutes;
  logic [5:0]         seconds;
  logic [9:0]         milliseconds;
  logic               running;
  logic [HOURS_W-1:0] lap_h;
  logic [5:0]         lap_m;
  logic [5:0]         lap_s;
  logic [9:0]         lap_ms;
  logic               lap_valid;
  logic               done;
  logic               overflow;

  modport master (
    output start_stop, clear, load, mode, lap, pre_h, pre_m, pre_s, pre_ms,
    input  hours, minutes, seconds, milliseconds, running,
           lap_h, lap_m, lap_s, lap_ms, lap_valid, done, overflow
  );

  modport slave (
    input  start_stop, clear, load, mode, lap, pre_h, pre_m, pre_s, pre_ms,
    output hours, minutes, seconds, milliseconds, running,
           lap_h, lap_m, lap_s, lap_ms, lap_valid, done, overflow
  );
endinterface

// File: rtl/chrono_counter.sv
// Stopwatch / countdown timer core: prescaled 1 ms tick, h:m:s:ms counter,
// run/stop, clear, saturating preset load and lap capture.
module chrono_counter #(
  parameter int TICK_DIV  = 1000,
  parameter int HOURS_W   = 4,
  parameter int MAX_HOURS = 10
) (
  input logic             clk,
  input logic             reset,
  chrono_counter_if.slave bus
);
  localparam int                 PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HOURS_W-1:0] H_LAST     = HOURS_W'(MAX_HOURS - 1);

  typedef enum logic {ST_STOPPED, ST_RUNNING} run_state_t;

  run_state_t         state, state_n;
  logic [PW-1:0]      presc, presc_n;
  logic [HOURS_W-1:0] h_q, h_n;
  logic [5:0]         m_q, m_n, s_q, s_n;
  logic [9:0]         ms_q, ms_n;
  logic               done_q, done_n, ovf_q, ovf_n;
  logic [HOURS_W-1:0] lap_h_q;
  logic [5:0]         lap_m_q, lap_s_q;
  logic [9:0]         lap_ms_q;
  logic               lap_valid_q;
  logic               tick, is_zero;

  // Next-state and next-time computation; priority clear > load > start_stop/tick.
  always_comb begin
    tick    = (state == ST_RUNNING) && (presc == PRESC_LAST);
    is_zero = (h_q == '0) && (m_q == '0) && (s_q == '0) && (ms_q == '0);
    state_n = state;
    presc_n = '0;
    h_n     = h_q;
    m_n     = m_q;
    s_n     = s_q;
    ms_n    = ms_q;
    done_n  = 1'b0;
    ovf_n   = 1'b0;

    if (state == ST_RUNNING) presc_n = tick ? '0 : presc + PW'(1);

    if (bus.clear) begin
      state_n = ST_STOPPED;
      presc_n = '0;
      h_n     = '0;
      m_n     = '0;
      s_n     = '0;
      ms_n    = '0;
    end else if (bus.load && state == ST_STOPPED) begin
      h_n  = (bus.pre_h  > H_LAST) ? H_LAST : bus.pre_h;
      m_n  = (bus.pre_m  > 6'd59)  ? 6'd59  : bus.pre_m;
      s_n  = (bus.pre_s  > 6'd59)  ? 6'd59  : bus.pre_s;
      ms_n = (bus.pre_ms > 10'd999) ? 10'd999 : bus.pre_ms;
    end else begin
      // A load while running falls through here, so it neither blocks start_stop nor the tick.
      if (tick) begin
        if (!bus.mode) begin
          if (ms_q == 10'd999) begin
            ms_n = '0;
            if (s_q == 6'd59) begin
              s_n = '0;
              if (m_q == 6'd59) begin
                m_n = '0;
                if (h_q == H_LAST) begin
                  h_n   = '0;
                  ovf_n = 1'b1;
                end else begin
                  h_n = h_q + HOURS_W'(1);
                end
              end else begin
                m_n = m_q + 6'd1;
              end
            end else begin
              s_n = s_q + 6'd1;
            end
          end else begin
            ms_n = ms_q + 10'd1;
          end
        end else begin
          // A down tick from 0.001 (or from zero after a mid-run mode flip) lands on zero and stops.
          if (h_q == '0 && m_q == '0 && s_q == '0 && ms_q <= 10'd1) begin
            ms_n    = '0;
            done_n  = 1'b1;
            state_n = ST_STOPPED;
          end else if (ms_q == '0) begin
            ms_n = 10'd999;
            if (s_q == '0) begin
              s_n = 6'd59;
              if (m_q == '0) begin
                m_n = 6'd59;
                h_n = h_q - HOURS_W'(1);
              end else begin
                m_n = m_q - 6'd1;
              end
            end else begin
              s_n = s_q - 6'd1;
            end
          end else begin
            ms_n = ms_q - 10'd1;
          end
        end
      end
      if (bus.start_stop) begin
        if (state == ST_RUNNING) state_n = ST_STOPPED;
        else if (!(bus.mode && is_zero)) state_n = ST_RUNNING;
      end
    end
  end

  // State, prescaler, time and status pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_STOPPED;
      presc  <= '0;
      h_q    <= '0;
      m_q    <= '0;
      s_q    <= '0;
      ms_q   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      h_q    <= h_n;
      m_q    <= m_n;
      s_q    <= s_n;
      ms_q   <= ms_n;
      done_q <= done_n;
      ovf_q  <= ovf_n;
    end
  end

  // Lap capture of the pre-tick value, with a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_h_q     <= '0;
      lap_m_q     <= '0;
      lap_s_q     <= '0;
      lap_ms_q    <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_valid_q <= bus.lap;
      if (bus.lap) begin
        lap_h_q  <= h_q;
        lap_m_q  <= m_q;
        lap_s_q  <= s_q;
        lap_ms_q <= ms_q;
      end
    end
  end

  assign bus.hours        = h_q;
  assign bus.minutes      = m_q;
  assign bus.seconds      = s_q;
  assign bus.milliseconds = ms_q;
  assign bus.running      = (state == ST_RUNNING);
  assign bus.lap_h        = lap_h_q;
  assign bus.lap_m        = lap_m_q;
  assign bus.lap_s        = lap_s_q;
  assign bus.lap_ms       = lap_ms_q;
  assign bus.lap_valid    = lap_valid_q;
  assign bus.done         = done_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_chrono_counter.sv
// Bench for chrono_counter: directed scenarios plus randomized traffic against
// a reference model that keeps time as a single millisecond count.
module tb_chrono_counter;
  localparam int TICK_DIV  = 4;
  localparam int HOURS_W   = 4;
  localparam int MAX_HOURS = 10;
  localparam int MOD_MS    = MAX_HOURS * 3600000;

  logic clk;
  logic reset;
  chrono_counter_if #(.HOURS_W(HOURS_W)) bus();

  chrono_counter #(.TICK_DIV(TICK_DIV), .HOURS_W(HOURS_W), .MAX_HOURS(MAX_HOURS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_t, m_phase, m_lap;
  bit m_run, m_lapv, m_done, m_ovf;

  logic [25:0] tv, lv;
  assign tv = {bus.hours, bus.minutes, bus.seconds, bus.milliseconds};
  assign lv = {bus.lap_h, bus.lap_m, bus.lap_s, bus.lap_ms};

  function automatic logic [25:0] fields(input int t);
    return {4'(t / 3600000), 6'((t / 60000) % 60), 6'((t / 1000) % 60), 10'(t % 1000)};
  endfunction

  function automatic int to_ms(input int h, input int m, input int s, input int ms);
    return ((h * 60 + m) * 60 + s) * 1000 + ms;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Apply one clock of inputs to DUT and model alike.
  task automatic step(input bit rs, input bit ss, input bit cl, input bit ld, input bit lp);
    int n_t, n_phase, n_lap;
    bit n_run, n_lapv, n_done, n_ovf, tk;
    reset = rs; bus.start_stop = ss; bus.clear = cl; bus.load = ld; bus.lap = lp;
    tk = m_run && (m_phase == TICK_DIV - 1);
    n_phase = m_run ? (tk ? 0 : m_phase + 1) : 0;
    n_t = m_t; n_run = m_run; n_done = 0; n_ovf = 0;
    n_lapv = lp; n_lap = lp ? m_t : m_lap;
    if (rs) begin
      n_t = 0; n_phase = 0; n_run = 0; n_lap = 0; n_lapv = 0;
    end else if (cl) begin
      n_t = 0; n_phase = 0; n_run = 0;
    end else if (ld && !m_run) begin
      n_t = to_ms(sat(int'(bus.pre_h), MAX_HOURS - 1), sat(int'(bus.pre_m), 59),
                  sat(int'(bus.pre_s), 59), sat(int'(bus.pre_ms), 999));
    end else begin
      if (tk) begin
        if (!bus.mode) begin
          n_t = (m_t + 1) % MOD_MS;
          n_ovf = (m_t == MOD_MS - 1);
        end else if (m_t <= 1) begin
          n_t = 0; n_done = 1; n_run = 0;
        end else begin
          n_t = m_t - 1;
        end
      end
      if (ss) begin
        if (m_run) n_run = 0;
        else if (!(bus.mode && m_t == 0)) n_run = 1;
      end
    end
    @(posedge clk);
    #1;
    m_t = n_t; m_phase = n_phase; m_lap = n_lap; m_run = n_run;
    m_lapv = n_lapv; m_done = n_done; m_ovf = n_ovf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic set_pre(input int h, input int m, input int s, input int ms);
    bus.pre_h = HOURS_W'(h); bus.pre_m = 6'(m); bus.pre_s = 6'(s); bus.pre_ms = 10'(ms);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    vectors++;
    if ({tv, lv, bus.running, bus.lap_valid, bus.done, bus.overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got time=%h lap=%h run=%b lv=%b done=%b ovf=%b, expected all 0",
               tv, lv, bus.running, bus.lap_valid, bus.done, bus.overflow);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_count_up;
    bus.mode = 1'b0;
    step(0, 1, 0, 0, 0);
    idle(3);
    vectors++;
    if (tv !== 26'd0) begin miscompares++; $display("FAIL up_before_tick: got %h expected 0", tv); end
    idle(1);
    vectors++;
    if (bus.milliseconds !== 10'd1) begin
      miscompares++; $display("FAIL up_first_tick: got ms=%0d expected 1", bus.milliseconds);
    end
    idle(16);
    vectors++;
    if (bus.milliseconds !== 10'd5 || bus.running !== 1'b1) begin
      miscompares++;
      $display("FAIL up_20_clks: got ms=%0d run=%b expected ms=5 run=1", bus.milliseconds, bus.running);
    end
  endtask

  task automatic test_wrap;
    bus.mode = 1'b0;
    step(0, 0, 1, 0, 0);
    set_pre(0, 59, 59, 998);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    idle(8);
    vectors++;
    if (tv !== {4'd1, 6'd0, 6'd0, 10'd0}) begin
      miscompares++; $display("FAIL carry_to_hour: got %h expected %h", tv, {4'd1, 6'd0, 6'd0, 10'd0});
    end
    step(0, 0, 1, 0, 0);
    set_pre(9, 59, 59, 999);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    idle(3);
    vectors++;
    if (bus.overflow !== 1'b0 || tv !== fields(MOD_MS - 1)) begin
      miscompares++; $display("FAIL pre_overflow: got time=%h ovf=%b expected %h ovf=0", tv, bus.overflow, fields(MOD_MS - 1));
    end
    idle(1);
    vectors++;
    if (tv !== 26'd0 || bus.overflow !== 1'b1 || bus.running !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_wrap: got time=%h ovf=%b run=%b expected 0 ovf=1 run=1", tv, bus.overflow, bus.running);
    end
    idle(1);
    vectors++;
    if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_width: got ovf=%b expected 0", bus.overflow); end
  endtask

  task automatic test_countdown;
    step(0, 0, 1, 0, 0);
    bus.mode = 1'b1;
    set_pre(0, 0, 0, 2);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    idle(4);
    vectors++;
    if (tv !== 26'd1 || bus.running !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL down_one: got time=%h run=%b done=%b expected 1 run=1 done=0", tv, bus.running, bus.done);
    end
    idle(4);
    vectors++;
    if (tv !== 26'd0 || bus.running !== 1'b0 || bus.done !== 1'b1) begin
      miscompares++; $display("FAIL down_done: got time=%h run=%b done=%b expected 0 run=0 done=1", tv, bus.running, bus.done);
    end
    idle(1);
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL done_width: got done=%b expected 0", bus.done); end
    step(0, 1, 0, 0, 0);
    idle(1);
    vectors++;
    if (bus.running !== 1'b0) begin miscompares++; $display("FAIL start_at_zero_down: got run=%b expected 0", bus.running); end
    // Random borrow chain across all fields
    step(0, 0, 1, 0, 0);
    set_pre($urandom_range(1, 9), 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    idle(4 * $urandom_range(1, 5));
    vectors++;
    if (tv !== fields(m_t) || bus.running !== m_run) begin
      miscompares++; $display("FAIL down_borrow: got %h run=%b expected %h run=%b", tv, bus.running, fields(m_t), m_run);
    end
  endtask

  task automatic test_lap;
    bus.mode = 1'b0;
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(31);
    vectors++;
    if (bus.milliseconds !== 10'd7) begin miscompares++; $display("FAIL lap_setup: got ms=%0d expected 7", bus.milliseconds); end
    step(0, 0, 0, 0, 1);
    vectors++;
    if (bus.lap_ms !== 10'd7 || bus.milliseconds !== 10'd8 || bus.lap_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lap_on_tick: got lap_ms=%0d ms=%0d lv=%b expected 7 8 1", bus.lap_ms, bus.milliseconds, bus.lap_valid);
    end
    idle(1);
    vectors++;
    if (bus.lap_valid !== 1'b0) begin miscompares++; $display("FAIL lap_valid_width: got %b expected 0", bus.lap_valid); end
    idle($urandom_range(0, 6));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      vectors++;
      if (lv !== fields(m_lap) || bus.lap_valid !== 1'b1) begin
        miscompares++; $display("FAIL lap_back_to_back: got lap=%h lv=%b expected %h lv=1", lv, bus.lap_valid, fields(m_lap));
      end
    end
  endtask

  task automatic test_clear_load;
    step(0, 1, 1, 0, 0);
    vectors++;
    if (tv !== 26'd0 || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL clear_with_stop: got time=%h run=%b expected 0 run=0", tv, bus.running);
    end
    step(0, 1, 0, 0, 0);
    set_pre($urandom_range(1, 9), 63, $urandom_range(0, 59), 1020);
    step(0, 0, 0, 1, 0);
    vectors++;
    if (tv !== 26'd0 || bus.running !== 1'b1) begin
      miscompares++; $display("FAIL load_while_running: got time=%h run=%b expected 0 run=1", tv, bus.running);
    end
    step(0, 1, 0, 0, 0);
    set_pre(15, 63, 45, 1020);
    step(0, 0, 0, 1, 0);
    vectors++;
    if (tv !== {4'd9, 6'd59, 6'd45, 10'd999} || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL load_saturate: got %h run=%b expected %h run=0", tv, bus.running, {4'd9, 6'd59, 6'd45, 10'd999});
    end
  endtask

  task automatic test_reset_mid;
    bus.mode = 1'b0;
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle($urandom_range(5, 40));
    step(1, 0, 0, 0, 0);
    vectors++;
    if ({tv, lv, bus.running, bus.lap_valid, bus.done, bus.overflow} !== '0) begin
      miscompares++; $display("FAIL reset_mid: got time=%h lap=%h run=%b expected all 0", tv, lv, bus.running);
    end
    step(0, 1, 0, 0, 0);
    idle(3);
    vectors++;
    if (tv !== 26'd0) begin miscompares++; $display("FAIL restart_early: got %h expected 0", tv); end
    idle(1);
    vectors++;
    if (tv !== 26'd1) begin miscompares++; $display("FAIL restart_first_tick: got %h expected 1", tv); end
  endtask

  task automatic test_random;
    bit ss, cl, ld, lp, rs;
    int sel;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 49) == 0) begin
        sel = $urandom_range(0, 2);
        if (sel == 0) set_pre(9, 59, 59, $urandom_range(990, 999));
        else if (sel == 1) set_pre(0, 0, 0, $urandom_range(0, 8));
        else set_pre($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1023));
      end
      rs = ($urandom_range(0, 999) == 0);
      cl = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 39) == 0);
      ss = ($urandom_range(0, 29) == 0);
      lp = ($urandom_range(0, 7) == 0);
      step(rs, ss, cl, ld, lp);
      vectors++;
      if (tv !== fields(m_t) || bus.running !== m_run || lv !== fields(m_lap) ||
          bus.lap_valid !== m_lapv || bus.done !== m_done || bus.overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL random[%0d]: got t=%h run=%b lap=%h lv=%b done=%b ovf=%b expected t=%h run=%b lap=%h lv=%b done=%b ovf=%b",
                 i, tv, bus.running, lv, bus.lap_valid, bus.done, bus.overflow,
                 fields(m_t), m_run, fields(m_lap), m_lapv, m_done, m_ovf);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.lap = 1'b0; bus.mode = 1'b0;
    set_pre(0, 0, 0, 0);
    m_t = 0; m_phase = 0; m_lap = 0; m_run = 0; m_lapv = 0; m_done = 0; m_ovf = 0;
    test_reset();
    test_count_up();
    test_wrap();
    test_countdown();
    test_lap();
    test_clear_load();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
